// File: rtl/uart_rx_if.sv
// UART receive-side bundle between the deserialiser and the CPU peripheral regs.
// master = receiver (produces bytes/status), slave = pin driver and CPU side.
interface uart_rx_if;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       busy;

  modport master (
    input  rx,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output rx_ready,
    output rx_overrun,
    output rx_frame_err,
    output busy
  );

  modport slave (
    output rx,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  rx_ready,
    input  rx_overrun,
    input  rx_frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-deep holding register and sticky
// overrun / framing-error status cleared by a CPU acknowledge pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  // The IDLE cycle that sees rx_s low is offset 0 of the start bit.
  localparam logic [CW-1:0] START_PT = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_PT   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          s1;
  logic          rx_s;
  logic          busy_q;

  logic [7:0]    data_q;
  logic          valid_q;
  logic          ready_q;
  logic          ovr_q;
  logic          ferr_q;

  logic          start_hit;
  logic          bit_hit;
  logic          deliver;
  logic          frame_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= bus.rx;
      rx_s <= s1;
    end
  end

  always_comb begin
    start_hit = 1'b0;
    bit_hit   = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    start_hit = (state == START) && (cnt == START_PT);
    bit_hit   = (cnt == BIT_PT);
    deliver   = (state == STOP) && bit_hit && rx_s;
    frame_bad = (state == STOP) && bit_hit && !rx_s;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (start_hit) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_hit) begin
            cnt    <= '0;
            busy_q <= !rx_s;
            state  <= rx_s ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // A delivery in the same cycle as an ack counts as consumed, not overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= deliver;
      if (deliver) begin
        data_q  <= shift;
        ready_q <= 1'b1;
      end else if (bus.rx_ack) begin
        ready_q <= 1'b0;
      end
      if (bus.rx_ack) begin
        ovr_q <= 1'b0;
      end else if (deliver && ready_q) begin
        ovr_q <= 1'b1;
      end
      if (frame_bad) begin
        ferr_q <= 1'b1;
      end else if (bus.rx_ack) begin
        ferr_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_ready     = ready_q;
  assign bus.rx_overrun   = ovr_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level status model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB  = 2;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic reset;
  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;

  logic [7:0] m_data;
  bit m_ready, m_ov, m_fe;

  wire [10:0] stat = {bus.rx_data, bus.rx_ready, bus.rx_overrun, bus.rx_frame_err};
  logic [10:0] mstat;

  always @(negedge clk)
    if (bus.rx_valid === 1'b1) vcnt++;

  function automatic void m_reset();
    m_data = 8'h00; m_ready = 0; m_ov = 0; m_fe = 0;
  endfunction

  function automatic void m_ack();
    m_ready = 0; m_ov = 0; m_fe = 0;
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit good, input bit ack);
    if (good) begin
      m_ov = ack ? 1'b0 : (m_ov | m_ready);
      if (ack) m_fe = 0;
      m_data = b;
      m_ready = 1;
    end else begin
      m_fe = 1;
      if (ack) begin m_ready = 0; m_ov = 0; end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    int v0;
    reset = 1'b0; bus.rx = 1'b1; bus.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_reset();
    repeat (50) @(negedge clk);
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if ({stat, bus.busy, bus.rx_valid} !== {mstat, 2'b00}) begin
      errors++; $display("FAIL reset_idle got %h exp %h", {stat, bus.busy, bus.rx_valid}, {mstat, 2'b00});
    end
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL reset_novalid got %0d exp 0", vcnt); end
    v0 = vcnt;
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b exp 1", bus.busy); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_abort_busy got %b exp 0", bus.busy); end
        reset = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    m_reset();
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (vcnt !== v0) begin errors++; $display("FAIL reset_abort_valid got %0d exp %0d", vcnt, v0); end
    checks++;
    if (stat !== mstat) begin errors++; $display("FAIL reset_abort_stat got %h exp %h", stat, mstat); end
  endtask

  task automatic test_single();
    int v0;
    v0 = vcnt;
    send_byte(8'h05, 1'b1);
    repeat (4) @(negedge clk);
    m_frame(8'h05, 1, 0);
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (vcnt !== v0 + 1) begin errors++; $display("FAIL single_pulse got %0d exp %0d", vcnt - v0, 1); end
    checks++;
    if ({stat, bus.busy} !== {mstat, 1'b0}) begin
      errors++; $display("FAIL single_stat got %h exp %h", {stat, bus.busy}, {mstat, 1'b0});
    end
    pulse_ack(); m_ack();
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (stat !== mstat) begin errors++; $display("FAIL single_ack got %h exp %h", stat, mstat); end
  endtask

  task automatic test_five();
    logic [7:0] seq [5] = '{8'h05, 8'h02, 8'h01, 8'h04, 8'h03};
    int v0;
    v0 = vcnt;
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i], 1'b1);
      repeat (4) @(negedge clk);
      m_frame(seq[i], 1, 0);
      mstat = {m_data, m_ready, m_ov, m_fe};
      checks++;
      if (stat !== mstat) begin errors++; $display("FAIL five_stat%0d got %h exp %h", i, stat, mstat); end
      pulse_ack(); m_ack();
      repeat (20) @(negedge clk);
    end
    checks++;
    if (vcnt !== v0 + 5) begin errors++; $display("FAIL five_pulses got %0d exp 5", vcnt - v0); end
  endtask

  task automatic test_overrun();
    int v0;
    v0 = vcnt;
    send_byte(8'h05, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (4) @(negedge clk);
    m_frame(8'h05, 1, 0);
    m_frame(8'h02, 1, 0);
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (vcnt !== v0 + 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", vcnt - v0); end
    checks++;
    if (stat !== mstat) begin errors++; $display("FAIL overrun_stat got %h exp %h", stat, mstat); end
    pulse_ack(); m_ack();
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (stat !== mstat) begin errors++; $display("FAIL overrun_ack got %h exp %h", stat, mstat); end
  endtask

  task automatic test_frame_break();
    int v0;
    v0 = vcnt;
    send_byte(8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    m_frame(8'hA5, 0, 0);
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (vcnt !== v0) begin errors++; $display("FAIL ferr_novalid got %0d exp 0", vcnt - v0); end
    checks++;
    if ({stat, bus.busy} !== {mstat, 1'b1}) begin
      errors++; $display("FAIL break_stat got %h exp %h", {stat, bus.busy}, {mstat, 1'b1});
    end
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL break_release got %b exp 0", bus.busy); end
    send_byte(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    m_frame(8'h3C, 1, 0);
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (stat !== mstat) begin errors++; $display("FAIL after_break got %h exp %h", stat, mstat); end
    pulse_ack(); m_ack();
  endtask

  task automatic test_glitch();
    int v0, bc;
    v0 = vcnt;
    bc = 0;
    bus.rx = 1'b0;
    @(negedge clk);
    bus.rx = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bc++;
    end
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (bc > HALF + 1) begin errors++; $display("FAIL glitch_busy got %0d cycles exp <= %0d", bc, HALF + 1); end
    checks++;
    if (vcnt !== v0 || stat !== mstat) begin
      errors++; $display("FAIL glitch_quiet got %0d/%h exp 0/%h", vcnt - v0, stat, mstat);
    end
  endtask

  task automatic test_collision();
    int v0;
    v0 = vcnt;
    send_byte(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    m_frame(8'h11, 1, 0);
    fork
      send_byte(8'h7E, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        pulse_ack();
      end
    join
    repeat (3) @(negedge clk);
    m_frame(8'h7E, 1, 1);
    mstat = {m_data, m_ready, m_ov, m_fe};
    checks++;
    if (stat !== mstat) begin errors++; $display("FAIL collision_stat got %h exp %h", stat, mstat); end
    checks++;
    if (vcnt !== v0 + 2) begin errors++; $display("FAIL collision_pulses got %0d exp 2", vcnt - v0); end
    pulse_ack(); m_ack();
  endtask

  task automatic test_random();
    int v0;
    logic [7:0] b;
    bit good, ack;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      ack = 1'($urandom_range(0, 1));
      v0 = vcnt;
      send_byte(b, good);
      repeat (4) @(negedge clk);
      m_frame(b, good, 0);
      mstat = {m_data, m_ready, m_ov, m_fe};
      checks++;
      if (vcnt !== v0 + int'(good)) begin
        errors++; $display("FAIL rand%0d_pulses got %0d exp %0d", i, vcnt - v0, int'(good));
      end
      checks++;
      if (stat !== mstat) begin errors++; $display("FAIL rand%0d_stat got %h exp %h", i, stat, mstat); end
      if (!good) begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
      end
      if (ack) begin
        pulse_ack(); m_ack();
        mstat = {m_data, m_ready, m_ov, m_fe};
        checks++;
        if (stat !== mstat) begin errors++; $display("FAIL rand%0d_ack got %h exp %h", i, stat, mstat); end
      end
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.rx = 1'b1;
    bus.rx_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_five();
    test_overrun();
    test_frame_break();
    test_glitch();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
